uart_receiver_control: RTL

Receive-side sequencer for the UART. Sits directly upstream of the receiver shift block: it drives that block's `voting_shift_en`, `receive_shift_en` and `error_check` strobes from the 16x baud tick, and detects and qualifies start bits. It counts frame bits per the LCR word length and parity settings, computes parity, and at frame end captures `rsr_data` and `frame_error` into a one-cycle `rx_valid` result for the RBR/FIFO.

---
 rtl/uart_receiver_control.sv | 218 +++++++++++++++++++++
 1 files changed

// File: rtl/uart_receiver_control.sv
// Receive-side sequencer for the UART: drives the shift block's vote/shift
// strobes from the oversampled baud tick, qualifies start bits, counts frame
// bits from the latched LCR settings and registers the per-frame result.
module uart_receiver_control #(
  parameter int unsigned OSR = 16
) (
  input  logic       pclk,
  input  logic       presetn,
  input  logic       baud_tick,
  input  logic       rx_en,
  input  logic [1:0] wls,
  input  logic       pen,
  input  logic       eps,
  input  logic       sp,
  input  logic       rx_data,
  input  logic       received_parity,
  input  logic       frame_error,
  input  logic [7:0] rsr_data,
  output logic       voting_shift_en,
  output logic       receive_shift_en,
  output logic       error_check,
  output logic       rx_valid,
  output logic [7:0] rx_dout,
  output logic       parity_err,
  output logic       frame_err,
  output logic       break_det,
  output logic       rx_busy
);

  localparam int unsigned CW = $clog2(OSR);
  localparam logic [CW-1:0] C_VOTE_LO  = CW'(OSR/2 - 1);
  localparam logic [CW-1:0] C_VOTE_MID = CW'(OSR/2);
  localparam logic [CW-1:0] C_VOTE_HI  = CW'(OSR/2 + 1);
  localparam logic [CW-1:0] C_CNT_MAX  = CW'(OSR - 1);
  localparam logic [CW-1:0] C_CNT_DET  = CW'(2);

  typedef enum logic [2:0] {
    S_IDLE,
    S_START,
    S_DATA,
    S_PARITY,
    S_STOP,
    S_DONE
  } state_t;

  state_t        r_state, w_state_nxt;
  logic [CW-1:0] r_cnt, w_cnt_nxt;
  logic [2:0]    r_bit, w_bit_nxt;
  logic [1:0]    r_wls;
  logic          r_pen, r_eps, r_sp;
  logic          r_acc, w_acc_nxt;
  logic          r_zero, w_zero_nxt;
  logic          r_vote_d;
  logic          r_mid, w_mid_nxt;
  logic          w_load_cfg, w_capture, w_ec_nxt;
  logic          w_active, w_window, w_false_start, w_parity_err;
  logic          r_error_check, r_rx_valid;
  logic [7:0]    r_rx_dout;
  logic          r_parity_err, r_frame_err, r_break_det, r_busy;

  // Strobe generation and mid-bit bookkeeping decoded from state and tick counter
  always_comb begin
    w_active = (r_state == S_START) || (r_state == S_DATA) ||
               (r_state == S_PARITY) || (r_state == S_STOP);
    w_window = (r_cnt == C_VOTE_LO) || (r_cnt == C_VOTE_MID) || (r_cnt == C_VOTE_HI);
    // rx_data only settles after the third vote, so the false-start decision and
    // the shift strobe share one cycle; a false start suppresses the strobe.
    w_false_start    = (r_state == S_START) && rx_data;
    voting_shift_en  = rx_en && baud_tick && ((r_state == S_IDLE) || (w_active && w_window));
    receive_shift_en = r_mid && rx_en && !w_false_start;
    w_mid_nxt        = rx_en && baud_tick && w_active && (r_cnt == C_VOTE_HI);
    if (r_sp) begin
      w_parity_err = r_pen && (received_parity != !r_eps);
    end else begin
      w_parity_err = r_pen && ((r_acc ^ received_parity) != !r_eps);
    end
  end

  // Next-state and datapath update logic
  always_comb begin
    w_state_nxt = r_state;
    w_cnt_nxt   = r_cnt;
    w_bit_nxt   = r_bit;
    w_acc_nxt   = r_acc;
    w_zero_nxt  = r_zero;
    w_load_cfg  = 1'b0;
    w_capture   = 1'b0;
    w_ec_nxt    = 1'b0;
    if (!rx_en) begin
      w_state_nxt = S_IDLE;
      w_cnt_nxt   = '0;
      w_bit_nxt   = '0;
    end else begin
      case (r_state)
        S_IDLE: begin
          w_cnt_nxt = '0;
          if (r_vote_d && !rx_data) begin
            w_state_nxt = S_START;
            w_cnt_nxt   = C_CNT_DET;
            w_bit_nxt   = '0;
            w_load_cfg  = 1'b1;
            w_acc_nxt   = 1'b0;
            w_zero_nxt  = 1'b1;
          end
        end
        S_START, S_DATA, S_PARITY, S_STOP: begin
          if (baud_tick) begin
            w_cnt_nxt = (r_cnt == C_CNT_MAX) ? '0 : r_cnt + CW'(1);
          end
          if (r_mid) begin
            case (r_state)
              S_START: begin
                if (rx_data) begin
                  w_state_nxt = S_IDLE;
                  w_cnt_nxt   = '0;
                end else begin
                  w_state_nxt = S_DATA;
                end
              end
              S_DATA: begin
                w_acc_nxt  = r_acc ^ rx_data;
                w_zero_nxt = r_zero & ~rx_data;
                w_bit_nxt  = r_bit + 3'd1;
                if (r_bit == ({1'b0, r_wls} + 3'd4)) begin
                  w_state_nxt = r_pen ? S_PARITY : S_STOP;
                end
              end
              S_PARITY: begin
                w_zero_nxt  = r_zero & ~rx_data;
                w_state_nxt = S_STOP;
              end
              default: begin
                w_zero_nxt  = r_zero & ~rx_data;
                w_state_nxt = S_DONE;
                w_ec_nxt    = 1'b1;
              end
            endcase
          end
        end
        default: begin
          w_state_nxt = S_IDLE;
          w_cnt_nxt   = '0;
          w_capture   = 1'b1;
        end
      endcase
    end
  end

  // FSM state register
  always_ff @(posedge pclk or negedge presetn) begin
    if (!presetn) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // Tick/bit counters, latched line configuration and frame accumulators
  always_ff @(posedge pclk or negedge presetn) begin
    if (!presetn) begin
      r_cnt    <= '0;
      r_bit    <= '0;
      r_wls    <= '0;
      r_pen    <= 1'b0;
      r_eps    <= 1'b0;
      r_sp     <= 1'b0;
      r_acc    <= 1'b0;
      r_zero   <= 1'b0;
      r_vote_d <= 1'b0;
      r_mid    <= 1'b0;
    end else begin
      r_cnt    <= w_cnt_nxt;
      r_bit    <= w_bit_nxt;
      r_acc    <= w_acc_nxt;
      r_zero   <= w_zero_nxt;
      r_vote_d <= voting_shift_en;
      r_mid    <= w_mid_nxt;
      if (w_load_cfg) begin
        r_wls <= wls;
        r_pen <= pen;
        r_eps <= eps;
        r_sp  <= sp;
      end
    end
  end

  // Registered result and status outputs
  always_ff @(posedge pclk or negedge presetn) begin
    if (!presetn) begin
      r_error_check <= 1'b0;
      r_rx_valid    <= 1'b0;
      r_rx_dout     <= '0;
      r_parity_err  <= 1'b0;
      r_frame_err   <= 1'b0;
      r_break_det   <= 1'b0;
      r_busy        <= 1'b0;
    end else begin
      r_error_check <= w_ec_nxt;
      r_rx_valid    <= w_capture;
      r_busy        <= (w_state_nxt != S_IDLE);
      if (w_capture) begin
        r_rx_dout    <= rsr_data;
        r_parity_err <= w_parity_err;
        r_frame_err  <= frame_error;
        r_break_det  <= r_zero;
      end
    end
  end

  assign error_check = r_error_check;
  assign rx_valid    = r_rx_valid;
  assign rx_dout     = r_rx_dout;
  assign parity_err  = r_parity_err;
  assign frame_err   = r_frame_err;
  assign break_det   = r_break_det;
  assign rx_busy     = r_busy;

endmodule
